comm_rx: RTL and testbench

COMM_RX -- requirements
Module: comm_rx

---
 rtl/comm_pkg.sv | 23 ++
 rtl/comm_rx_sync_2ff.sv | 40 ++++
 rtl/comm_rx.sv | 185 ++++++++++++++++++
 tb/tb_comm_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_pkg
// Description : Shared definitions for the serial receiver: default bit
//               timing, payload width and the receive FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int C_DEF_CLKS_PER_BIT = 434;
  localparam int C_DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

endpackage : comm_pkg
`default_nettype wire

// File: rtl/comm_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit, with a
//               configurable reset value so an idle-high line reads idle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next value of each stage: first stage captures the pin, second the first
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer stages; both come out of reset at the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/comm_rx.sv
`default_nettype none
// ============================================================================
// Module      : comm_rx
// Description : Serial (8N1-style) receiver with mid-bit sampling, a single
//               holding register and sticky framing/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_rx
  import comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = C_DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = C_DEF_DATA_BITS
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 c_rx,
  input  logic                 rx_ack,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int C_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int C_BIT_W = $clog2(DATA_BITS + 1);
  // Start bit is checked half a bit in so every later sample lands mid-bit
  localparam logic [C_CNT_W-1:0] C_HALF_CNT = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_load;
  logic                 w_stop_bad;

  rx_state_e            state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [C_BIT_W-1:0]   bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
  logic                 ovr_q,   ovr_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .i_d (c_rx),
    .o_q (w_rxs)
  );

  // Frame decoder: bit timing, LSB-first shifting and stop-bit verdict
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    w_load     = 1'b0;
    w_stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!w_rxs) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == C_HALF_CNT) begin
          cnt_d   = '0;
          // A line already back high mid start bit was only a glitch
          state_d = w_rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == C_FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {w_rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == C_LAST_BIT) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + C_BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == C_FULL_CNT) begin
          cnt_d = '0;
          if (w_rxs) begin
            w_load  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w_stop_bad = 1'b1;
            state_d    = ST_WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      ST_WAIT_HI: begin
        // A held-low line (break) must not look like a stream of start bits
        cnt_d = '0;
        if (w_rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Holding register and sticky flags; a setting event beats err_clr
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (w_load) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end
    if (w_stop_bad) begin
      ferr_d = 1'b1;
    end
  end

  // Decoder state registers
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Consumer-facing registers
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule : comm_rx
`default_nettype wire

// File: tb/tb_comm_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_rx
// Description : Self-checking bench for comm_rx at 16 clocks per bit, with a
//               frame-level reference model of the holding register/flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_rx;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * CPB;
  // Stop-bit sample edge counted from the start edge: 2 sync + 1 idle
  // detect + half bit + data bits + stop bit; ack/clr are driven on the
  // falling edge just before it.
  localparam int LOAD_I = 2 + 1 + CPB / 2 + (DB + 1) * CPB - 1;

  logic          sys_clk_i;
  logic          sys_rst_i;
  logic          c_rx;
  logic          rx_ack;
  logic          err_clr;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the consumer should see
  logic          m_valid, m_ferr, m_ovr, m_busy;
  logic [DB-1:0] m_data;

  comm_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .c_rx      (c_rx),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  function automatic string fmt();
    return $sformatf("got v=%b d=%h fe=%b ov=%b busy=%b, want v=%b d=%h fe=%b ov=%b busy=%b",
                     rx_valid, rx_data, frame_err, overrun, rx_busy,
                     m_valid, m_data, m_ferr, m_ovr, m_busy);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    c_rx = 1'b1;
    repeat (n) @(negedge sys_clk_i);
    if (n >= 4) m_busy = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge sys_clk_i);
    rx_ack = 1'b0;
    @(negedge sys_clk_i);
    m_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge sys_clk_i);
    err_clr = 1'b0;
    @(negedge sys_clk_i);
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Drive one frame; stop level is held for one bit plus hold_low extra cycles
  task automatic send_frame(input logic [DB-1:0] b, input bit stop_ok, input int hold_low,
                            input bit ack_on_load, input bit clr_on_load);
    int slot;
    for (int i = 0; i < FRAME + hold_low; i++) begin
      slot = i / CPB;
      if (slot == 0)       c_rx = 1'b0;
      else if (slot <= DB) c_rx = b[slot-1];
      else                 c_rx = stop_ok;
      rx_ack  = ack_on_load && (i == LOAD_I);
      err_clr = clr_on_load && (i == LOAD_I);
      @(negedge sys_clk_i);
    end
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    if (clr_on_load) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (stop_ok) begin
      if (!m_valid || ack_on_load) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
    m_busy = !stop_ok;
  endtask

  task automatic test_reset();
    sys_rst_i = 1'b1; c_rx = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk_i);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL reset_held: %s", fmt());
    end
    sys_rst_i = 1'b0;
    idle(10);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL reset_released: %s", fmt());
    end
  endtask

  task automatic test_frame_a5();
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL frame_a5: %s", fmt());
    end
    pulse_ack();
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL ack_a5: %s", fmt());
    end
    idle(8);
  endtask

  task automatic test_glitch();
    c_rx = 1'b0;
    repeat (4) @(negedge sys_clk_i);
    c_rx = 1'b1;
    repeat (4) @(negedge sys_clk_i);
    m_busy = 1'b1;  // still checking the start bit
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL glitch_mid: %s", fmt());
    end
    idle(20);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL glitch_end: %s", fmt());
    end
  endtask

  task automatic test_break();
    send_frame(8'h3C, 1'b0, 50, 1'b0, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL break_low: %s", fmt());
    end
    idle(10);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL break_released: %s", fmt());
    end
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL after_break_11: %s", fmt());
    end
    pulse_ack();
    pulse_clr();
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL break_cleared: %s", fmt());
    end
    idle(8);
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1, 0, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h02, 1'b1, 0, 1'b0, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL overrun_set: %s", fmt());
    end
    pulse_clr();
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL overrun_clr: %s", fmt());
    end
    pulse_ack();
    idle(8);
  endtask

  task automatic test_ack_on_load();
    send_frame(8'h33, 1'b1, 0, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h55, 1'b1, 0, 1'b1, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL ack_on_load_55: %s", fmt());
    end
    pulse_ack();
    idle(8);
  endtask

  task automatic test_clr_collision();
    send_frame(8'h21, 1'b1, 0, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
    idle(10);
    // err_clr on the same cycle as a bad stop bit: overrun clears, frame_err sets
    send_frame(8'h0F, 1'b0, 0, 1'b0, 1'b1);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL clr_collision: %s", fmt());
    end
    idle(10);
    pulse_ack();
    pulse_clr();
    idle(4);
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] b;
    int slot;
    send_frame(8'h99, 1'b1, 0, 1'b0, 1'b0);
    idle(10);
    b = 8'h7E;
    // Stop halfway through data bit 4
    for (int i = 0; i < (5 * CPB + CPB / 2); i++) begin
      slot = i / CPB;
      c_rx = (slot == 0) ? 1'b0 : b[slot-1];
      @(negedge sys_clk_i);
    end
    sys_rst_i = 1'b1;
    c_rx      = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL reset_midframe: %s", fmt());
    end
    repeat (3) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    idle(20);
    send_frame(8'h7E, 1'b1, 0, 1'b0, 1'b0);
    n_vec++;
    if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
      n_err++; $display("FAIL after_reset_7e: %s", fmt());
    end
    pulse_ack();
    idle(8);
  endtask

  task automatic test_random();
    logic [DB-1:0] b;
    bit good, ackl;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) pulse_ack();
      if ($urandom_range(0, 3) == 0) pulse_clr();
      b    = DB'($urandom);
      good = ($urandom_range(0, 4) != 0);
      ackl = good && ($urandom_range(0, 3) == 0);
      send_frame(b, good, good ? 0 : int'($urandom_range(0, 30)), ackl, 1'b0);
      n_vec++;
      if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
        n_err++; $display("FAIL random_frame_%0d: %s", k, fmt());
      end
      idle(int'($urandom_range(4, 40)));
      n_vec++;
      if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
        n_err++; $display("FAIL random_gap_%0d: %s", k, fmt());
      end
    end
  endtask

  // Guard against a stalled run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_break();
    test_overrun();
    test_ack_on_load();
    test_clr_collision();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_comm_rx
`default_nettype wire
